// File: rtl/gpu_raster_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | gpu_raster_pkg : shared raster constants and line-stepper FSM.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package gpu_raster_pkg;

  localparam int WIDTH = 10;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int ERR_W = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/line_setup.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | line_setup : combinational octant normalisation for Bresenham.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module line_setup
  import gpu_raster_pkg::*;
(
  input  logic [WIDTH-1:0]        x0,
  input  logic [WIDTH-1:0]        y0,
  input  logic [WIDTH-1:0]        x1,
  input  logic [WIDTH-1:0]        y1,
  output logic                    steep,
  output logic [WIDTH-1:0]        xs,
  output logic [WIDTH-1:0]        ys,
  output logic [WIDTH-1:0]        xe,
  output logic [WIDTH-1:0]        dx,
  output logic [WIDTH-1:0]        dy,
  output logic                    ystep_neg,
  output logic signed [ERR_W-1:0] err_init
);

  logic [WIDTH-1:0] w_adx, w_ady;
  logic [WIDTH-1:0] w_ax0, w_ay0, w_ax1, w_ay1;
  logic [WIDTH-1:0] w_ye;
  logic             w_swap;

  assign w_adx = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
  assign w_ady = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
  assign steep = (w_ady > w_adx);

  // Axis swap puts the longer delta on x so the stepper always advances x.
  assign w_ax0 = steep ? y0 : x0;
  assign w_ay0 = steep ? x0 : y0;
  assign w_ax1 = steep ? y1 : x1;
  assign w_ay1 = steep ? x1 : y1;

  assign w_swap = (w_ax0 > w_ax1);
  assign xs     = w_swap ? w_ax1 : w_ax0;
  assign ys     = w_swap ? w_ay1 : w_ay0;
  assign xe     = w_swap ? w_ax0 : w_ax1;
  assign w_ye   = w_swap ? w_ay0 : w_ay1;

  assign dx        = xe - xs;
  assign ystep_neg = (w_ye < ys);
  assign dy        = ystep_neg ? (ys - w_ye) : (w_ye - ys);
  assign err_init  = $signed({2'b00, dx >> 1});

endmodule
`default_nettype wire

// File: rtl/bresenham_line_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | bresenham_line_gen : one pixel/cycle Bresenham line stepper     |
// | with ready/valid back-pressure. Option: RASTER_CLIP_EN.         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module bresenham_line_gen
  import gpu_raster_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [WIDTH-1:0] x_coord,
  output logic [WIDTH-1:0] y_coord,
  output logic             steep,
  output logic             busy,
  output logic             done
);

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic [WIDTH-1:0]        r_x, r_y, r_xe, r_dx, r_dy;
  logic                    r_ystep_neg, r_steep;
  logic signed [ERR_W-1:0] r_err, w_err_n;

  logic                    w_steep, w_ystep_neg;
  logic [WIDTH-1:0]        w_xs, w_ys, w_xe, w_dx, w_dy;
  logic signed [ERR_W-1:0] w_err_init;
  logic                    w_clip, w_adv, w_last;

  line_setup u_setup (
    .x0        (r_x0),
    .y0        (r_y0),
    .x1        (r_x1),
    .y1        (r_y1),
    .steep     (w_steep),
    .xs        (w_xs),
    .ys        (w_ys),
    .xe        (w_xe),
    .dx        (w_dx),
    .dy        (w_dy),
    .ystep_neg (w_ystep_neg),
    .err_init  (w_err_init)
  );

`ifdef RASTER_CLIP_EN
  logic [WIDTH-1:0] w_sx, w_sy;
  assign w_sx   = r_steep ? r_y : r_x;
  assign w_sy   = r_steep ? r_x : r_y;
  // Off-screen pixels are skipped without waiting for the consumer.
  assign w_clip = (r_state == DRAW) &&
                  ((32'(w_sx) >= H_RES) || (32'(w_sy) >= V_RES));
`else
  assign w_clip = 1'b0;
`endif

  assign w_adv   = (r_state == DRAW) && (pix_ready || w_clip);
  assign w_last  = (r_x == r_xe);
  assign w_err_n = r_err - $signed({2'b00, r_dy});

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    pix_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = SETUP;
      end
      SETUP: w_state_nxt = DRAW;
      DRAW: begin
        pix_valid = !w_clip;
        if (w_adv && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_xe        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_ystep_neg <= 1'b0;
      r_steep     <= 1'b0;
      r_err       <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_x0 <= x0;
          r_y0 <= y0;
          r_x1 <= x1;
          r_y1 <= y1;
        end
        SETUP: begin
          r_steep     <= w_steep;
          r_x         <= w_xs;
          r_y         <= w_ys;
          r_xe        <= w_xe;
          r_dx        <= w_dx;
          r_dy        <= w_dy;
          r_ystep_neg <= w_ystep_neg;
          r_err       <= w_err_init;
        end
        DRAW: if (w_adv) begin
          r_x <= r_x + 1'b1;
          if (w_err_n[ERR_W-1]) begin
            r_y   <= r_ystep_neg ? (r_y - 1'b1) : (r_y + 1'b1);
            r_err <= w_err_n + $signed({2'b00, r_dx});
          end else begin
            r_err <= w_err_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_coord = r_x;
  assign y_coord = r_y;
  assign steep   = r_steep;

endmodule
`default_nettype wire

// File: tb/tb_bresenham_line_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_bresenham_line_gen : directed self-checking bench.           |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_bresenham_line_gen;
  import gpu_raster_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, pix_ready;
  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic             pix_valid, steep, busy, done;
  logic [WIDTH-1:0] x_coord, y_coord;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] cap_x[$];
  logic [WIDTH-1:0] cap_y[$];
  logic             cap_steep;
  int               first_k, done_k, done_cnt, hold_viol;
  bit               timeout;

  bresenham_line_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .x_coord   (x_coord),
    .y_coord   (y_coord),
    .steep     (steep),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Issues one command and records handshaked pixels; k counts edges since start was sampled.
  // mode 0: ready held high; mode 1: ready 1,0,0 repeating from the first DRAW cycle.
  task automatic draw_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int mode, input int inj_k);
    logic [WIDTH-1:0] hx, hy;
    bit holding;
    cap_x.delete(); cap_y.delete();
    first_k = -1; done_k = -1; done_cnt = 0; hold_viol = 0; timeout = 0;
    holding = 0; hx = '0; hy = '0; cap_steep = 1'b0;
    x0 = WIDTH'(ax0); y0 = WIDTH'(ay0); x1 = WIDTH'(ax1); y1 = WIDTH'(ay1);
    start = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 300 && done_k < 0; k++) begin
      pix_ready = (mode == 0) ? 1'b1 : (((k - 2) % 3) == 0);
      if (k == inj_k) begin
        start = 1'b1; x0 = 10'd7; y0 = 10'd7; x1 = 10'd9; y1 = 10'd9;
      end else begin
        start = 1'b0;
      end
      if (holding && (x_coord !== hx || y_coord !== hy || pix_valid !== 1'b1)) hold_viol++;
      holding = 0;
      if (pix_valid === 1'b1 && first_k < 0) first_k = k;
      if (pix_valid === 1'b1) cap_steep = steep;
      if (pix_valid === 1'b1 && pix_ready) begin
        cap_x.push_back(x_coord); cap_y.push_back(y_coord);
      end else if (pix_valid === 1'b1) begin
        holding = 1; hx = x_coord; hy = y_coord;
      end
      if (done === 1'b1) begin done_k = k; done_cnt++; end
      @(posedge clk); #1;
    end
    start = 1'b0; pix_ready = 1'b1;
    if (done_k < 0) timeout = 1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({pix_valid, busy, done, steep} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b exp 0000", {pix_valid, busy, done, steep});
    end
    n_vec++;
    if ({x_coord, y_coord} !== 20'd0) begin
      n_err++; $display("FAIL reset_coords: got (%0d,%0d) exp (0,0)", x_coord, y_coord);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{0, 0, 1, 1, 2};
    draw_line(0, 0, 4, 2, 0, -1);
    n_vec++;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got 1 exp 0"); end
    n_vec++;
    if (cap_x.size() !== 5) begin
      n_err++; $display("FAIL basic_count: got %0d exp 5", cap_x.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== ex[i] || int'(cap_y[i]) !== ey[i]) begin
        n_err++;
        $display("FAIL basic_pix%0d: got (%0d,%0d) exp (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
    n_vec++;
    if (cap_steep !== 1'b0) begin n_err++; $display("FAIL basic_steep: got %b exp 0", cap_steep); end
    n_vec++;
    if (first_k !== 2) begin n_err++; $display("FAIL basic_latency: got %0d exp 2", first_k); end
    n_vec++;
    if (done_k !== 7) begin n_err++; $display("FAIL basic_done_cycle: got %0d exp 7", done_k); end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_width: got %0d exp 1", done_cnt); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b exp 0", busy); end
  endtask

  task automatic test_reverse();
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{0, 0, 1, 1, 2};
    draw_line(4, 2, 0, 0, 0, -1);
    n_vec++;
    if (cap_x.size() !== 5 || timeout) begin
      n_err++; $display("FAIL reverse_count: got %0d exp 5", cap_x.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== ex[i] || int'(cap_y[i]) !== ey[i]) begin
        n_err++;
        $display("FAIL reverse_pix%0d: got (%0d,%0d) exp (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
    n_vec++;
    if (cap_steep !== 1'b0) begin n_err++; $display("FAIL reverse_steep: got %b exp 0", cap_steep); end
  endtask

  task automatic test_steep();
    int ex[4] = '{0, 1, 2, 3};
    int ey[4] = '{0, 0, 1, 1};
    draw_line(0, 0, 1, 3, 0, -1);
    n_vec++;
    if (cap_x.size() !== 4 || timeout) begin
      n_err++; $display("FAIL steep_count: got %0d exp 4", cap_x.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== ex[i] || int'(cap_y[i]) !== ey[i]) begin
        n_err++;
        $display("FAIL steep_pix%0d: got (%0d,%0d) exp (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
    n_vec++;
    if (cap_steep !== 1'b1) begin n_err++; $display("FAIL steep_flag: got %b exp 1", cap_steep); end
  endtask

  task automatic test_neg_ystep();
    int ex[7] = '{0, 1, 2, 3, 4, 5, 6};
    int ey[7] = '{3, 3, 2, 2, 1, 1, 0};
    draw_line(0, 3, 6, 0, 0, -1);
    n_vec++;
    if (cap_x.size() !== 7 || timeout) begin
      n_err++; $display("FAIL negy_count: got %0d exp 7", cap_x.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== ex[i] || int'(cap_y[i]) !== ey[i]) begin
        n_err++;
        $display("FAIL negy_pix%0d: got (%0d,%0d) exp (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_single_and_ignore_start();
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{0, 0, 1, 1, 2};
    draw_line(5, 5, 5, 5, 0, -1);
    n_vec++;
    if (cap_x.size() !== 1 || timeout) begin
      n_err++; $display("FAIL single_count: got %0d exp 1", cap_x.size());
    end
    n_vec++;
    if (cap_x.size() < 1 || int'(cap_x[0]) !== 5 || int'(cap_y[0]) !== 5) begin
      n_err++; $display("FAIL single_pix: got (%0d,%0d) exp (5,5)", cap_x[0], cap_y[0]);
    end
    n_vec++;
    if (cap_steep !== 1'b0 || done_k !== 3 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL single_done: got steep=%b done_k=%0d cnt=%0d exp steep=0 done_k=3 cnt=1",
               cap_steep, done_k, done_cnt);
    end
    // A start pulsed mid-DRAW must neither disturb this line nor queue another.
    draw_line(0, 0, 4, 2, 0, 3);
    n_vec++;
    if (cap_x.size() !== 5 || timeout || done_cnt !== 1) begin
      n_err++; $display("FAIL ignore_count: got %0d pixels %0d dones exp 5 and 1", cap_x.size(), done_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== ex[i] || int'(cap_y[i]) !== ey[i]) begin
        n_err++;
        $display("FAIL ignore_pix%0d: got (%0d,%0d) exp (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy: got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    draw_line(0, 0, 9, 0, 1, -1);
    n_vec++;
    if (cap_x.size() !== 10 || timeout) begin
      n_err++; $display("FAIL bp_count: got %0d exp 10", cap_x.size());
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== i || int'(cap_y[i]) !== 0) begin
        n_err++; $display("FAIL bp_pix%0d: got (%0d,%0d) exp (%0d,0)", i, cap_x[i], cap_y[i], i);
      end
    end
    n_vec++;
    if (hold_viol !== 0) begin n_err++; $display("FAIL bp_hold: got %0d changes exp 0", hold_viol); end
    n_vec++;
    if (done_k !== 30 || done_cnt !== 1) begin
      n_err++; $display("FAIL bp_done: got k=%0d cnt=%0d exp k=30 cnt=1", done_k, done_cnt);
    end
  endtask

  task automatic test_reset_mid_line();
    bit seen_done;
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; y1 = 10'd0;
    start = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (pix_valid !== 1'b1 || x_coord !== 10'd2) begin
      n_err++; $display("FAIL rstmid_pre: got valid=%b x=%0d exp valid=1 x=2", pix_valid, x_coord);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({pix_valid, busy, done} !== 3'b000 || x_coord !== 10'd0) begin
      n_err++; $display("FAIL rstmid_post: got %b x=%0d exp 000 x=0", {pix_valid, busy, done}, x_coord);
    end
    seen_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin n_err++; $display("FAIL rstmid_nodone: got 1 exp 0"); end
    draw_line(0, 0, 4, 2, 0, -1);
    n_vec++;
    if (cap_x.size() !== 5 || timeout || done_cnt !== 1 ||
        int'(cap_x[4]) !== 4 || int'(cap_y[4]) !== 2) begin
      n_err++; $display("FAIL rstmid_restart: got %0d pixels last (%0d,%0d) exp 5 last (4,2)",
                        cap_x.size(), cap_x[4], cap_y[4]);
    end
  endtask

  task automatic test_clip();
    int exp_n;
`ifdef RASTER_CLIP_EN
    exp_n = 10;
`else
    exp_n = 21;
`endif
    draw_line(630, 0, 650, 0, 0, -1);
    n_vec++;
    if (cap_x.size() !== exp_n || timeout) begin
      n_err++; $display("FAIL clip_count: got %0d exp %0d", cap_x.size(), exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      n_vec++;
      if (i >= cap_x.size() || int'(cap_x[i]) !== 630 + i || int'(cap_y[i]) !== 0) begin
        n_err++; $display("FAIL clip_pix%0d: got (%0d,%0d) exp (%0d,0)", i, cap_x[i], cap_y[i], 630 + i);
      end
    end
    n_vec++;
    if (done_k !== 23 || done_cnt !== 1) begin
      n_err++; $display("FAIL clip_steps: got done_k=%0d cnt=%0d exp 23 and 1", done_k, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_steep();
    test_neg_ystep();
    test_single_and_ignore_start();
    test_backpressure();
    test_reset_mid_line();
    test_clip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 exp finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
